// File: rtl/jtag_mem_bridge.sv
// JTAG TAP to memory-controller bridge.
// Standard 16-state TAP with IR, IDCODE and BYPASS. Three user data registers
// (SET_ADDR, SET_DATA, SET_CTRL) launch single read/write accesses on a simple
// sel/we/addr/wdata request interface. Supports optional address auto-increment
// and an access timeout that reports an error status.
// Ports:
//   tck, jtag_rst       - the only clock; synchronous active-high reset
//   tms, tdi            - TAP mode select and serial data in
//   tdo, enable_tdo     - serial data out and its output enable
//   ready, rdata        - asynchronous controller idle flag and read data
//   sel, we, addr, wdata - access request towards the memory controller
module jtag_mem_bridge #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IR_W        = 4,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              tck,
  input  logic              jtag_rst,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              enable_tdo,
  input  logic              ready,
  input  logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  localparam int unsigned DrA  = (ADDR_W > 32) ? ADDR_W : 32;
  localparam int unsigned DrW  = (DATA_W + 2 > DrA) ? DATA_W + 2 : DrA;
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [IR_W-1:0] InstIdcode  = IR_W'(1);
  localparam logic [IR_W-1:0] InstSetAddr = {{(IR_W-1){1'b1}}, 1'b0};
  localparam logic [IR_W-1:0] InstSetData = {{(IR_W-2){1'b1}}, 2'b00};
  localparam logic [IR_W-1:0] InstSetCtrl = {{(IR_W-3){1'b1}}, 3'b000};

  typedef enum logic [3:0] {
    StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPauseDr, StEx2Dr, StUpdDr,
    StSelIr, StCapIr, StShIr, StEx1Ir, StPauseIr, StEx2Ir, StUpdIr
  } tap_state_e;

  typedef enum logic [2:0] {DrBypass, DrIdcode, DrAddr, DrData, DrCtrl} dr_sel_e;

  tap_state_e state_q, state_d;
  dr_sel_e    dr_sel;

  logic [IR_W-1:0]        ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [DrW-1:0]         dr_q, dr_d;
  logic [SYNC_STAGES-1:0] ready_sync_q, ready_sync_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d, rdata_reg_q, rdata_reg_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic sel_q, sel_d, we_q, we_d, last_read_q, last_read_d;
  logic auto_inc_q, auto_inc_d, err_q, err_d;
  logic idle, rise, timeout_hit;
  logic [1:0] cmd;

  // ---------------- TAP FSM: state register ----------------
  always_ff @(posedge tck) begin
    if (jtag_rst) state_q <= StTlr;
    else          state_q <= state_d;
  end

  // ---------------- TAP FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:     state_d = tms ? StTlr     : StRti;
      StRti:     state_d = tms ? StSelDr   : StRti;
      StSelDr:   state_d = tms ? StSelIr   : StCapDr;
      StCapDr:   state_d = tms ? StEx1Dr   : StShDr;
      StShDr:    state_d = tms ? StEx1Dr   : StShDr;
      StEx1Dr:   state_d = tms ? StUpdDr   : StPauseDr;
      StPauseDr: state_d = tms ? StEx2Dr   : StPauseDr;
      StEx2Dr:   state_d = tms ? StUpdDr   : StShDr;
      StUpdDr:   state_d = tms ? StSelDr   : StRti;
      StSelIr:   state_d = tms ? StTlr     : StCapIr;
      StCapIr:   state_d = tms ? StEx1Ir   : StShIr;
      StShIr:    state_d = tms ? StEx1Ir   : StShIr;
      StEx1Ir:   state_d = tms ? StUpdIr   : StPauseIr;
      StPauseIr: state_d = tms ? StEx2Ir   : StPauseIr;
      StEx2Ir:   state_d = tms ? StUpdIr   : StShIr;
      StUpdIr:   state_d = tms ? StSelDr   : StRti;
      default:   state_d = StTlr;
    endcase
  end

  // ---------------- TAP FSM: outputs ----------------
  always_comb begin
    enable_tdo = 1'b0;
    tdo        = 1'b0;
    if (state_q == StShDr) begin
      enable_tdo = 1'b1;
      tdo        = dr_q[0];
    end else if (state_q == StShIr) begin
      enable_tdo = 1'b1;
      tdo        = ir_sr_q[0];
    end
  end

  // Unlisted instruction codes fall back to BYPASS.
  always_comb begin
    case (ir_q)
      InstIdcode:  dr_sel = DrIdcode;
      InstSetAddr: dr_sel = DrAddr;
      InstSetData: dr_sel = DrData;
      InstSetCtrl: dr_sel = DrCtrl;
      default:     dr_sel = DrBypass;
    endcase
  end

  assign idle        = ready_sync_q[SYNC_STAGES-1];
  assign rise        = !ready_sync_q[SYNC_STAGES-1] && ready_sync_q[SYNC_STAGES-2];
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign cmd         = dr_q[1:0];

  // ---------------- Datapath next state ----------------
  always_comb begin
    ir_d         = ir_q;
    ir_sr_d      = ir_sr_q;
    dr_d         = dr_q;
    ready_sync_d = {ready_sync_q[SYNC_STAGES-2:0], ready};
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_reg_d  = rdata_reg_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    we_d         = we_q;
    last_read_d  = last_read_q;
    auto_inc_d   = auto_inc_q;
    err_d        = err_q;

    unique case (state_q)
      StTlr:   ir_d    = InstIdcode;
      StCapIr: ir_sr_d = IR_W'(1);
      StShIr:  ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
      StUpdIr: ir_d    = ir_sr_q;
      StCapDr: begin
        unique case (dr_sel)
          DrIdcode: dr_d = DrW'(IDCODE_VAL);
          DrAddr:   dr_d = DrW'(addr_q);
          DrCtrl:   dr_d = DrW'(auto_inc_q);
          DrData: begin
            if (err_q) begin
              dr_d  = DrW'(2'b11);
              err_d = 1'b0;
            end else if (sel_q || !idle) begin
              dr_d = DrW'(2'b01);
            end else if (last_read_q) begin
              dr_d = DrW'({rdata_reg_q, 2'b10});
            end else begin
              dr_d = DrW'({wdata_q, 2'b10});
            end
          end
          default:  dr_d = '0;
        endcase
      end
      StShDr: begin
        unique case (dr_sel)
          DrIdcode: dr_d[31:0]         = {tdi, dr_q[31:1]};
          DrAddr:   dr_d[ADDR_W-1:0]   = {tdi, dr_q[ADDR_W-1:1]};
          DrData:   dr_d[DATA_W+1:0]   = {tdi, dr_q[DATA_W+1:1]};
          default:  dr_d[0]            = tdi;
        endcase
      end
      StUpdDr: begin
        unique case (dr_sel)
          DrAddr: if (!sel_q) addr_d = dr_q[ADDR_W-1:0];
          DrCtrl: auto_inc_d = dr_q[0];
          DrData: begin
            if ((cmd == 2'b01 || cmd == 2'b10) && !sel_q && idle) begin
              sel_d       = 1'b1;
              we_d        = (cmd == 2'b10);
              last_read_d = (cmd == 2'b01);
              cnt_d       = '0;
              if (cmd == 2'b10) wdata_d = dr_q[DATA_W+1:2];
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    // Completion beats timeout when both land on the same edge.
    if (sel_q) begin
      if (rise) begin
        sel_d = 1'b0;
        if (last_read_q) rdata_reg_d = rdata;
        if (auto_inc_q)  addr_d      = addr_q + ADDR_W'(1);
      end else if (timeout_hit) begin
        sel_d = 1'b0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge tck) begin
    if (jtag_rst) begin
      ir_q         <= InstIdcode;
      ir_sr_q      <= '0;
      dr_q         <= '0;
      ready_sync_q <= '1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_reg_q  <= '0;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      last_read_q  <= 1'b0;
      auto_inc_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ir_q         <= ir_d;
      ir_sr_q      <= ir_sr_d;
      dr_q         <= dr_d;
      ready_sync_q <= ready_sync_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_reg_q  <= rdata_reg_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      last_read_q  <= last_read_d;
      auto_inc_q   <= auto_inc_d;
      err_q        <= err_d;
    end
  end

  assign sel   = sel_q;
  assign we    = we_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Testbench for jtag_mem_bridge with default parameters: a table of TAP pin
// vectors followed by directed access sequences against a hand-driven memory.
module tb_jtag_mem_bridge;

  logic        tck = 1'b0;
  logic        jtag_rst, tms, tdi, tdo, enable_tdo, ready, sel, we;
  logic [15:0] rdata, wdata;
  logic [7:0]  addr;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct packed {
    logic tms;
    logic tdi;
    logic en;
    logic tdo;
  } vec_t;

  vec_t        vecs [29];
  logic [63:0] d;
  int          n;

  always #5 tck = ~tck;

  jtag_mem_bridge dut (
    .tck        (tck),
    .jtag_rst   (jtag_rst),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .enable_tdo (enable_tdo),
    .ready      (ready),
    .rdata      (rdata),
    .sel        (sel),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clk(input logic m, input logic t);
    tms = m;
    tdi = t;
    @(posedge tck);
    #1;
  endtask

  // Starts and ends in Run-Test/Idle.
  task automatic shift_ir(input logic [3:0] code);
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) clk(i == 3, code[i]);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  // Starts and ends in Run-Test/Idle; the update has taken effect on return.
  task automatic shift_dr(input logic [63:0] din, input int len, output logic [63:0] dout);
    dout = '0;
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      dout[i] = tdo;
      clk(i == len - 1, din[i]);
    end
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  task automatic wait_sel_low(input int bound, output int cnt);
    cnt = 0;
    while (sel === 1'b1 && cnt < bound) begin
      clk(1'b0, 1'b0);
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // {tms, tdi, expected enable_tdo, expected tdo}
    vecs = '{
      4'b0000, 4'b1000, 4'b0000, 4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0010, // IDCODE bits 0..4
      4'b1000, 4'b1000, 4'b0000,                                               // exit to RTI
      4'b1000, 4'b1000, 4'b0000, 4'b0011, 4'b0110, 4'b0110, 4'b0110, 4'b1100, // IR <= 1111
      4'b1000, 4'b0000,
      4'b1000, 4'b0000, 4'b0010, 4'b0111, 4'b0010, 4'b1100, 4'b1000, 4'b0000  // bypass echo
    };

    jtag_rst = 1'b1;
    tms      = 1'b1;
    tdi      = 1'b0;
    ready    = 1'b1;
    rdata    = '0;
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    jtag_rst = 1'b0;

    check("rst_sel", sel, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_en", enable_tdo, 0);
    check("rst_tdo", tdo, 0);

    for (int i = 0; i < 29; i++) begin
      clk(vecs[i].tms, vecs[i].tdi);
      check($sformatf("vec%0d_en", i), enable_tdo, vecs[i].en);
      check($sformatf("vec%0d_tdo", i), tdo, vecs[i].tdo);
    end

    // Write access.
    shift_ir(4'hE);
    shift_dr(64'h3C, 8, d);
    check("addr_capture_reset", d, 0);
    check("addr_set", addr, 8'h3C);
    shift_ir(4'hC);
    shift_dr({16'hA55A, 2'b10}, 18, d);
    check("wr_capture_initial", d, 18'h2);
    check("wr_sel", sel, 1);
    check("wr_we", we, 1);
    check("wr_addr", addr, 8'h3C);
    check("wr_wdata", wdata, 16'hA55A);
    ready = 1'b0;
    repeat (4) clk(1'b0, 1'b0);
    ready = 1'b1;
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    check("wr_sel_still_high", sel, 1);
    clk(1'b0, 1'b0);
    check("wr_sel_fall", sel, 0);
    shift_dr(64'h0, 18, d);
    check("wr_capture_okay", d, {16'hA55A, 2'b10});

    // Auto-increment read with wrap.
    shift_ir(4'h8);
    shift_dr(64'h1, 1, d);
    check("ctrl_capture", d, 0);
    shift_ir(4'hE);
    shift_dr(64'hFF, 8, d);
    check("addr_capture_3c", d, 8'h3C);
    shift_ir(4'hC);
    shift_dr({16'h0, 2'b01}, 18, d);
    check("rd_sel", sel, 1);
    check("rd_we", we, 0);
    check("rd_addr", addr, 8'hFF);
    ready = 1'b0;
    rdata = 16'h1234;
    repeat (4) clk(1'b0, 1'b0);
    ready = 1'b1;
    wait_sel_low(10, n);
    check("rd_latency", n, 3);
    check("rd_addr_wrap", addr, 8'h00);
    shift_dr(64'h0, 18, d);
    check("rd_capture", d, {16'h1234, 2'b10});

    // Timeout on a read that never completes.
    shift_dr({16'h0, 2'b01}, 18, d);
    ready = 1'b0;
    rdata = 16'hDEAD;
    wait_sel_low(300, n);
    check("to_cycles", n, 255);
    check("to_sel", sel, 0);
    check("to_addr_unchanged", addr, 8'h00);
    ready = 1'b1;
    repeat (5) clk(1'b0, 1'b0);
    shift_dr(64'h0, 18, d);
    check("to_capture_err", d, 18'h3);
    shift_dr(64'h0, 18, d);
    check("to_capture_cleared", d, {16'h1234, 2'b10});

    // Write issued while a read is outstanding.
    shift_dr({16'h0, 2'b01}, 18, d);
    ready = 1'b0;
    check("busy_sel", sel, 1);
    shift_dr({16'hBEEF, 2'b10}, 18, d);
    check("busy_capture", d, 18'h1);
    check("busy_we_kept", we, 0);
    check("busy_wdata_kept", wdata, 16'hA55A);
    shift_dr(64'h0, 18, d);
    check("busy_capture2", d, 18'h1);
    ready = 1'b1;
    wait_sel_low(10, n);
    check("busy_done", sel, 0);
    check("busy_addr_inc", addr, 8'h01);

    // TMS-driven logic reset forces IDCODE.
    repeat (5) clk(1'b1, 1'b0);
    check("tlr_en", enable_tdo, 0);
    clk(1'b0, 1'b0);
    shift_dr(64'h0, 32, d);
    check("tlr_idcode", d, 32'h1000_0001);

    // Command dropped while the synchronised ready is low.
    shift_ir(4'hC);
    ready = 1'b0;
    repeat (4) clk(1'b0, 1'b0);
    shift_dr({16'h5555, 2'b10}, 18, d);
    check("notidle_capture", d, 18'h1);
    check("notidle_sel", sel, 0);
    check("notidle_wdata", wdata, 16'hA55A);
    ready = 1'b1;
    repeat (4) clk(1'b0, 1'b0);

    // Reset in the middle of an access.
    shift_dr({16'h0, 2'b01}, 18, d);
    check("mid_sel", sel, 1);
    ready    = 1'b0;
    jtag_rst = 1'b1;
    clk(1'b0, 1'b0);
    jtag_rst = 1'b0;
    check("mid_rst_sel", sel, 0);
    check("mid_rst_addr", addr, 0);
    ready = 1'b1;
    repeat (5) clk(1'b0, 1'b0);
    check("mid_stale_rise", sel, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtag_mem_bridge.md
Name: jtag_mem_bridge

Overview:
- Parametrised JTAG TAP-to-memory-controller bridge.
- Next generation of the fixed 8-bit-address / 16-bit-data JTAG controller. Adds configurable widths, IDCODE, a 1-bit BYPASS, address auto-increment, access timeout with an error status, and TMS-driven logic reset.
- Sits between the board JTAG pins and the memory controller request interface.

Parameters:
- ADDR_W, 8: address width.
- DATA_W, 16: data width.
- IR_W, 4: instruction register length, minimum 4.
- IDCODE_VAL, 32'h1000_0001: IDCODE register value; bit0 must be 1.
- SYNC_STAGES, 3: ready synchroniser depth, minimum 2.
- TIMEOUT_CYC, 255: tck cycles allowed per access; 0 disables the timeout.

Ports:
- tck, input, 1: the only clock; all flops on rising edge.
- jtag_rst, input, 1: synchronous, active-high reset.
- tms, input, 1: TAP mode select.
- tdi, input, 1: serial data in.
- tdo, output, 1: serial data out.
- enable_tdo, output, 1: tdo output enable.
- ready, input, 1: memory controller idle flag, asynchronous; high = idle.
- rdata, input, DATA_W: memory read data, stable while ready is high.
- sel, output, 1: access request.
- we, output, 1: 1 = write, 0 = read; valid while sel is high.
- addr, output, ADDR_W: access address.
- wdata, output, DATA_W: write data.

Behaviour:
- Reset (jtag_rst=1 at a tck edge):
  - TAP state TEST_LOGIC_RESET; IR = IDCODE.
  - sel=0, we=0, addr=0, wdata=0, rdata_reg=0, auto_inc=0, err=0, timeout count 0.
  - ready_sync all ones; tdo=0, enable_tdo=0.
- TAP FSM: standard IEEE 1149.1, 16 states, advanced on rising tck. While in TEST_LOGIC_RESET, IR is forced to IDCODE; datapath registers are not touched.
- tdo and enable_tdo are combinational from registered state:
  - enable_tdo = state is SHIFT_DR or SHIFT_IR.
  - tdo = LSB of the selected shift register, or 0 when not shifting.
- IR:
  - CAPTURE_IR loads 1 at bit0, 0 elsewhere.
  - SHIFT_IR shifts tdi into the MSB; UPDATE_IR loads IR.
- Instructions (IR_W bits):
  - BYPASS = all ones.
  - IDCODE = 1.
  - SET_ADDR = ones with bit0 = 0.
  - SET_DATA = ones with bits[1:0] = 0.
  - SET_CTRL = ones with bits[2:0] = 0.
  - Any other code behaves as BYPASS.
- DR lengths and CAPTURE_DR values (all shift LSB-first, tdi into the MSB):
  - BYPASS: 1 bit, captures 0.
  - IDCODE: 32 bits, captures IDCODE_VAL.
  - SET_ADDR: ADDR_W bits, captures addr.
  - SET_CTRL: 1 bit, captures auto_inc.
  - SET_DATA: DATA_W+2 bits, captures {payload, status}:
    - err=1 → {0, 2'b11}; err clears on this capture.
    - else sel=1 or synced ready=0 → {0, 2'b01} (BUSY).
    - else last access was a read → {rdata_reg, 2'b10} (OKAY).
    - else → {wdata, 2'b10} (OKAY).
- UPDATE_DR actions:
  - SET_ADDR: addr <= shifted value; ignored while sel=1.
  - SET_CTRL: auto_inc <= shifted bit.
  - SET_DATA: cmd = shifted[1:0].
    - 01 = READ, 10 = WRITE, 00 and 11 = no-op.
    - A READ or WRITE is accepted only if sel=0 and synced ready=1; otherwise it is dropped silently.
    - On accept: sel<=1, we<=(cmd==WRITE), last_read<=(cmd==READ). WRITE also loads wdata<=shifted[DATA_W+1:2].
- Ready synchroniser: shift ready into ready_sync[0] each edge.
  - idle = ready_sync[SYNC_STAGES-1].
  - rise = !ready_sync[SYNC_STAGES-1] & ready_sync[SYNC_STAGES-2].
- Completion: rise & sel → sel<=0; if read, rdata_reg<=rdata; if auto_inc, addr<=addr+1, wrapping modulo 2^ADDR_W. With SYNC_STAGES=3, sel falls 2 edges after the first edge that samples ready high.
- Timeout: counter clears when sel is set and increments each cycle while sel=1. Reaching TIMEOUT_CYC without a rise → sel<=0, err<=1, no addr increment, rdata_reg unchanged.
- Simultaneous events: rise on the same edge as timeout expiry completes normally, with no error. Completion and a SET_DATA UPDATE_DR on the same edge: the command is dropped (sel still 1 at evaluation).
- Reset mid-access: sel drops on the reset edge; the memory controller finishes on its own; the stale ready rise is ignored because sel=0.

Test Plan:
- Reset, then 5 DR-shift bits with IR=IDCODE → tdo streams IDCODE_VAL LSB-first (1,0,0,0,0); enable_tdo=1 only in SHIFT_DR.
- SET_ADDR 8'h3C, then SET_DATA {16'hA55A, 2'b10}; model drops ready for 4 cycles → sel=1, we=1, addr=8'h3C, wdata=16'hA55A; sel=0 two edges after ready is sampled high; next capture returns {16'hA55A, 2'b10}.
- SET_CTRL 1, addr 8'hFF, READ with model returning 16'h1234 → capture {16'h1234, 2'b10}; addr wraps to 8'h00.
- Hold ready=0 after a READ with TIMEOUT_CYC=255 → sel falls after 255 cycles; next SET_DATA capture returns status 2'b11, the following one returns 2'b10; addr unchanged.
- Issue a WRITE while sel=1 → no new request and wdata unchanged; capture reports status 2'b01.
- IR=SET_DATA, hold tms=1 for 5 cycles → TEST_LOGIC_RESET with IR=IDCODE; assert jtag_rst mid-access → sel=0 and addr=0 on the next edge.
